// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control for the bus datapath.
// Strobes decode combinationally from state and opcode; one instruction at a time.
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_output,
   input  logic        stop,
   output logic        PCout,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        Cout,
   output logic        InPortout,
   output logic        MAR_enable,
   output logic        MDR_enable,
   output logic        IR_enable,
   output logic        Y_enable,
   output logic        Z_low_enable,
   output logic        Z_high_enable,
   output logic        PC_enable,
   output logic        HI_enable,
   output logic        LO_enable,
   output logic        OutPort_enable,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        CON_in,
   output logic        GRA,
   output logic        GRB,
   output logic        GRC,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [4:0]  operation,
   output logic        run
);

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam int FETCH_CYCLES = 3;

   typedef enum logic [3:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam state_t S_DECODE = state_t'(FETCH_CYCLES - 1);

   state_t     state;
   state_t     last;
   logic       active;
   logic [4:0] opc;
   logic       unused_ir;

   logic c_alu, c_imm, c_una, c_md, c_ldi, c_ld, c_st, c_addr;
   logic c_br, c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo, c_halt;

   assign opc       = IR[31:27];
   assign unused_ir = ^IR[26:0];

   assign c_ld   = (opc == 5'd0);
   assign c_ldi  = (opc == 5'd1);
   assign c_st   = (opc == 5'd2);
   assign c_alu  = (opc >= 5'd3) && (opc <= 5'd11);
   assign c_imm  = (opc >= 5'd12) && (opc <= 5'd14);
   assign c_md   = (opc == 5'd15) || (opc == 5'd16);
   assign c_una  = (opc == 5'd17) || (opc == 5'd18);
   assign c_br   = (opc == 5'd19);
   assign c_jr   = (opc == 5'd20);
   assign c_jal  = (opc == 5'd21);
   assign c_in   = (opc == 5'd22);
   assign c_out  = (opc == 5'd23);
   assign c_mfhi = (opc == 5'd24);
   assign c_mflo = (opc == 5'd25);
   assign c_halt = (opc == 5'd27);
   // ld/st/ldi share the base+offset address computation in T3-T5
   assign c_addr = c_ld | c_st | c_ldi;

   always_comb begin
      last = S_T2;
      unique case (1'b1)
         c_alu, c_imm, c_ldi:               last = S_T5;
         c_ld, c_st:                        last = S_T7;
         c_br, c_md:                        last = S_T6;
         c_una, c_jal:                      last = S_T4;
         c_jr, c_in, c_out, c_mfhi, c_mflo: last = S_T3;
         default:                           last = S_T2;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state  <= S_T0;
         active <= 1'b0;
      end else begin
         active <= 1'b1;
         if (active) begin
            unique case (state)
               S_T0:     if (!stop) state <= S_T1;
               S_HALT:   state <= S_HALT;
               S_DECODE: begin
                  if (c_halt)
                     state <= S_HALT;
                  else if (last == S_T2)
                     state <= S_T0;
                  else
                     state <= S_T3;
               end
               default: begin
                  if (state == last)
                     state <= S_T0;
                  else
                     state <= state_t'(state + 4'd1);
               end
            endcase
         end
      end
   end

   assign run = active && (state != S_HALT);

   always_comb begin
      {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout} = '0;
      {MAR_enable, MDR_enable, IR_enable, Y_enable, Z_low_enable} = '0;
      {Z_high_enable, PC_enable, HI_enable, LO_enable, OutPort_enable} = '0;
      {IncPC, Read, Write, CON_in} = '0;
      {GRA, GRB, GRC, Rin, Rout, BAout} = '0;
      operation = '0;
      if (active) begin
         unique case (state)
            S_T0: if (!stop) begin
               PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1;
            end
            S_T1: begin
               Read = 1'b1; MDR_enable = 1'b1;
            end
            S_T2: begin
               MDRout = 1'b1; IR_enable = 1'b1;
            end
            S_T3: unique case (1'b1)
               c_alu, c_imm: begin GRB = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
               c_addr: begin GRB = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
               c_una: begin
                  GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = opc;
               end
               c_md:   begin GRA = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
               c_br:   begin GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
               c_jr:   begin GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
               c_jal:  begin PCout = 1'b1; GRB = 1'b1; Rin = 1'b1; end
               c_in:   begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               c_out:  begin GRA = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1; end
               c_mfhi: begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               c_mflo: begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               default: ;
            endcase
            S_T4: unique case (1'b1)
               c_alu: begin
                  GRC = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = opc;
               end
               c_imm: begin Cout = 1'b1; Z_low_enable = 1'b1; operation = opc; end
               c_addr: begin Cout = 1'b1; Z_low_enable = 1'b1; operation = OP_ADD; end
               c_una: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               c_md: begin
                  GRB = 1'b1; Rout = 1'b1; operation = opc;
                  Z_low_enable = 1'b1; Z_high_enable = 1'b1;
               end
               c_br:  begin PCout = 1'b1; Y_enable = 1'b1; end
               c_jal: begin GRA = 1'b1; Rout = 1'b1; PC_enable = 1'b1; end
               default: ;
            endcase
            S_T5: unique case (1'b1)
               c_alu, c_imm, c_ldi: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               c_ld, c_st: begin ZLowout = 1'b1; MAR_enable = 1'b1; end
               c_md: begin ZLowout = 1'b1; LO_enable = 1'b1; end
               c_br: begin Cout = 1'b1; Z_low_enable = 1'b1; operation = OP_ADD; end
               default: ;
            endcase
            S_T6: unique case (1'b1)
               c_ld: begin Read = 1'b1; MDR_enable = 1'b1; end
               c_st: begin GRA = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; end
               c_md: begin ZHighout = 1'b1; HI_enable = 1'b1; end
               c_br: begin ZLowout = 1'b1; PC_enable = CON_output; end
               default: ;
            endcase
            S_T7: unique case (1'b1)
               c_ld: begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               c_st: Write = 1'b1;
               default: ;
            endcase
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction streams checked every cycle against
// per-instruction strobe sequences derived from the instruction descriptions.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] IR = '0;
   logic        CON_output = 1'b0;
   logic        stop = 1'b0;

   logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
   logic MAR_enable, MDR_enable, IR_enable, Y_enable, Z_low_enable;
   logic Z_high_enable, PC_enable, HI_enable, LO_enable, OutPort_enable;
   logic IncPC, Read, Write, CON_in;
   logic GRA, GRB, GRC, Rin, Rout, BAout;
   logic [4:0] operation;
   logic run;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .clear(clear), .IR(IR),
      .CON_output(CON_output), .stop(stop),
      .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout),
      .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
      .Cout(Cout), .InPortout(InPortout),
      .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
      .IR_enable(IR_enable), .Y_enable(Y_enable),
      .Z_low_enable(Z_low_enable), .Z_high_enable(Z_high_enable),
      .PC_enable(PC_enable), .HI_enable(HI_enable),
      .LO_enable(LO_enable), .OutPort_enable(OutPort_enable),
      .IncPC(IncPC), .Read(Read), .Write(Write), .CON_in(CON_in),
      .GRA(GRA), .GRB(GRB), .GRC(GRC),
      .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .operation(operation), .run(run)
   );

   localparam int PCO = 27, ZLO = 26, ZHO = 25, MDRO = 24;
   localparam int HIO = 23, LOO = 22, CO = 21, INO = 20;
   localparam int MARE = 19, MDRE = 18, IRE = 17, YE = 16, ZLE = 15;
   localparam int ZHE = 14, PCE = 13, HIE = 12, LOE = 11, OPE = 10;
   localparam int INC = 9, RD = 8, WR = 7, CONI = 6;
   localparam int GA = 5, GB = 4, GC = 3, RI = 2, RO = 1, BA = 0;

   logic [27:0] act;
   assign act = {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
                 MAR_enable, MDR_enable, IR_enable, Y_enable, Z_low_enable,
                 Z_high_enable, PC_enable, HI_enable, LO_enable, OutPort_enable,
                 IncPC, Read, Write, CON_in, GRA, GRB, GRC, Rin, Rout, BAout};

   int checks = 0;
   int failures = 0;

   logic [27:0] exp_vec = '0;
   logic [4:0]  exp_op = '0;
   logic        exp_run = 1'b0;
   bit          exp_valid = 1'b0;
   string       exp_tag = "init";

   always @(negedge clock) begin
      if (exp_valid) begin
         checks++;
         if (act !== exp_vec || operation !== exp_op || run !== exp_run) begin
            failures++;
            $display("FAIL %s: strobes=%h op=%b run=%b required strobes=%h op=%b run=%b",
                     exp_tag, act, operation, run, exp_vec, exp_op, exp_run);
         end
      end
   end

   task automatic pin(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   function automatic logic [27:0] bt(input int i);
      bt = 28'd1 << i;
   endfunction

   function automatic int len_of(input logic [4:0] o);
      if (o == 0 || o == 2) len_of = 8;
      else if (o == 1 || (o >= 3 && o <= 14)) len_of = 6;
      else if (o == 15 || o == 16 || o == 19) len_of = 7;
      else if (o == 17 || o == 18 || o == 21) len_of = 5;
      else if (o == 20 || (o >= 22 && o <= 25)) len_of = 4;
      else len_of = 3;
   endfunction

   task automatic model(input logic [4:0] o, input int t, input logic con,
                        output logic [27:0] v, output logic [4:0] op);
      v = '0;
      op = '0;
      case (t)
         0: v = bt(PCO) | bt(MARE) | bt(INC);
         1: v = bt(RD) | bt(MDRE);
         2: v = bt(MDRO) | bt(IRE);
         default: begin
            if (o >= 3 && o <= 14) begin
               if (t == 3) v = bt(GB) | bt(RO) | bt(YE);
               if (t == 4) begin
                  v = ((o <= 11) ? (bt(GC) | bt(RO)) : bt(CO)) | bt(ZLE);
                  op = o;
               end
               if (t == 5) v = bt(ZLO) | bt(GA) | bt(RI);
            end else if (o <= 2) begin
               if (t == 3) v = bt(GB) | bt(BA) | bt(YE);
               if (t == 4) begin v = bt(CO) | bt(ZLE); op = 5'b00011; end
               if (t == 5) v = (o == 1) ? (bt(ZLO) | bt(GA) | bt(RI))
                                        : (bt(ZLO) | bt(MARE));
               if (t == 6) v = (o == 0) ? (bt(RD) | bt(MDRE))
                                        : (bt(GA) | bt(RO) | bt(MDRE));
               if (t == 7) v = (o == 0) ? (bt(MDRO) | bt(GA) | bt(RI)) : bt(WR);
            end else if (o == 15 || o == 16) begin
               if (t == 3) v = bt(GA) | bt(RO) | bt(YE);
               if (t == 4) begin
                  v = bt(GB) | bt(RO) | bt(ZLE) | bt(ZHE);
                  op = o;
               end
               if (t == 5) v = bt(ZLO) | bt(LOE);
               if (t == 6) v = bt(ZHO) | bt(HIE);
            end else if (o == 17 || o == 18) begin
               if (t == 3) begin v = bt(GB) | bt(RO) | bt(ZLE); op = o; end
               if (t == 4) v = bt(ZLO) | bt(GA) | bt(RI);
            end else if (o == 19) begin
               if (t == 3) v = bt(GA) | bt(RO) | bt(CONI);
               if (t == 4) v = bt(PCO) | bt(YE);
               if (t == 5) begin v = bt(CO) | bt(ZLE); op = 5'b00011; end
               if (t == 6) v = bt(ZLO) | (con ? bt(PCE) : 28'd0);
            end else if (o == 20) begin
               v = bt(GA) | bt(RO) | bt(PCE);
            end else if (o == 21) begin
               if (t == 3) v = bt(PCO) | bt(GB) | bt(RI);
               if (t == 4) v = bt(GA) | bt(RO) | bt(PCE);
            end else if (o == 22) begin
               v = bt(INO) | bt(GA) | bt(RI);
            end else if (o == 23) begin
               v = bt(GA) | bt(RO) | bt(OPE);
            end else if (o == 24) begin
               v = bt(HIO) | bt(GA) | bt(RI);
            end else if (o == 25) begin
               v = bt(LOO) | bt(GA) | bt(RI);
            end
         end
      endcase
   endtask

   task automatic cyc(input logic [27:0] v, input logic [4:0] op, input logic r);
      exp_vec = v;
      exp_op = op;
      exp_run = r;
      exp_valid = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // n reset edges; the first cycle still shows what the DUT was doing
   task automatic do_reset(input logic [27:0] v, input logic [4:0] op,
                           input logic r, input int n);
      clear = 1'b0;
      cyc(v, op, r);
      exp_tag = "in_reset";
      for (int k = 1; k < n; k++) cyc('0, '0, 1'b0);
      clear = 1'b1;
      cyc('0, '0, 1'b0);
   endtask

   task automatic run_instr(input logic [4:0] o, input int stall,
                            input int con_mode, input int abort_at,
                            input bit pin_en);
      logic [27:0] v;
      logic [4:0]  op;
      IR = {o, 27'($urandom)};
      for (int s = 0; s < stall; s++) begin
         stop = 1'b1;
         CON_output = 1'($urandom);
         exp_tag = $sformatf("stall_op%0d", o);
         if (pin_en) begin
            #1;
            pin("stall_mar_inc_run", {30'd0, MAR_enable, IncPC}, 32'd0);
         end
         cyc('0, '0, 1'b1);
      end
      for (int t = 0; t < len_of(o); t++) begin
         stop = (t == 0) ? 1'b0 : 1'($urandom);
         CON_output = (con_mode == 2) ? 1'($urandom) : con_mode[0];
         model(o, t, CON_output, v, op);
         exp_tag = $sformatf("op%0d_t%0d", o, t);
         if (t == abort_at) begin
            do_reset(v, op, 1'b1, 1);
            return;
         end
         if (pin_en) begin
            #1;
            if (t == 0)
               pin("t0_fetch", {28'd0, PCout, MAR_enable, IncPC, run}, 32'hF);
            if (o == 0 && t == 4) pin("ld_t4_op", {27'd0, operation}, 32'h3);
            if (o == 0 && t == 7)
               pin("ld_t7", {28'd0, MDRout, GRA, Rin, Read}, 32'hE);
            if (o == 3 && t == 4)
               pin("add_t4", {26'd0, operation, Z_low_enable}, 32'h7);
            if (o == 19 && t == 6)
               pin("br_t6_pc", {31'd0, PC_enable}, {31'd0, CON_output});
            if (o == 16 && t == 5)
               pin("mul_t5", {30'd0, LO_enable, HI_enable}, 32'h2);
            if (o == 16 && t == 6)
               pin("mul_t6", {30'd0, LO_enable, HI_enable}, 32'h1);
            if (o == 2 && t == 6)
               pin("st_t6", {29'd0, Read, MDR_enable, Write}, 32'h2);
            if (o == 2 && t == 7)
               pin("st_t7", {29'd0, Read, MDR_enable, Write}, 32'h1);
         end
         cyc(v, op, 1'b1);
      end
      if (o == 27) begin
         for (int k = 0; k < 4; k++) begin
            stop = 1'($urandom);
            CON_output = 1'($urandom);
            exp_tag = "halted";
            if (pin_en && k == 3) begin
               #1;
               pin("halt_run", {31'd0, run}, 32'd0);
            end
            cyc('0, '0, 1'b0);
         end
         do_reset('0, '0, 1'b0, 1);
      end
   endtask

   initial begin
      logic [4:0] o;
      int ab;
      @(posedge clock);
      #1;
      exp_tag = "reset";
      stop = 1'b1;
      cyc('0, '0, 1'b0);
      clear = 1'b1;
      cyc('0, '0, 1'b0);

      run_instr(5'd0, 0, 2, -1, 1'b1);
      run_instr(5'd3, 0, 2, -1, 1'b1);
      run_instr(5'd19, 0, 0, -1, 1'b1);
      run_instr(5'd19, 0, 1, -1, 1'b1);
      run_instr(5'd16, 0, 2, -1, 1'b1);
      run_instr(5'd2, 0, 2, -1, 1'b1);
      run_instr(5'd26, 3, 2, -1, 1'b1);
      run_instr(5'd0, 0, 2, 5, 1'b0);
      run_instr(5'd0, 1, 2, -1, 1'b1);

      for (int i = 0; i < 400; i++) begin
         o = 5'($urandom);
         if (o == 27 && $urandom_range(0, 3) != 0) o = 5'd26;
         ab = -1;
         if (o != 27 && $urandom_range(0, 19) == 0)
            ab = $urandom_range(0, len_of(o) - 1);
         run_instr(o, $urandom_range(0, 2), 2, ab, 1'b0);
      end

      run_instr(5'd27, 1, 2, -1, 1'b1);
      run_instr(5'd30, 0, 2, -1, 1'b0);
      exp_valid = 1'b0;
      @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
